// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_unit_pkg
// Purpose  : Definitions shared by the fetch stage and the control decoder:
//            fetch FSM state encoding and the primary opcode constants.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_EXEC = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        EXEC = ST_EXEC
    } fetch_state_t;

    // Primary opcodes (instr[31:26]); the decoder uses the same table
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Field extractors so fetch and decode slice the word identically
    function automatic logic [5:0] instr_op(input logic [31:0] word);
        return word[31:26];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [31:0] word);
        return word[5:0];
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_unit_if
// Purpose   : Instruction-memory request/response bundle.
//             master = fetch stage, slave = instruction memory.
// Signals   : imem_req    fetch request valid            (master -> slave)
//             imem_addr   fetch address                  (master -> slave)
//             imem_ready  request accepted this cycle    (slave -> master)
//             imem_rvalid read data valid                (slave -> master)
//             imem_rdata  instruction word               (slave -> master)
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int PC_WIDTH = 32
) ();

    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_logic
// Purpose  : Purely combinational next-PC selection.
//            jump            -> {pc_plus4[top:28], instr[25:0], 2'b00}
//            branch & zero   -> pc_plus4 + (signext(instr[15:0]) << 2)
//            otherwise       -> pc_plus4
//            All sums wrap modulo 2^PC_WIDTH.
// Ports    : pc_plus4  in   PC_WIDTH  sequential successor of the PC
//            instr     in   32        instruction being retired
//            branch    in   1         decoder Branch
//            jump      in   1         decoder Jump (wins over branch)
//            zero      in   1         ALU zero flag
//            next_pc   out  PC_WIDTH  selected next PC
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_logic
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc_plus4,
    input  logic [31:0]         instr,
    input  logic                branch,
    input  logic                jump,
    input  logic                zero,
    output logic [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] w_branch_offset;
    logic [PC_WIDTH-1:0] w_branch_target;
    logic [PC_WIDTH-1:0] w_jump_target;
    logic                w_unused_opcode;

    // Sign-extended word offset; a negative immediate wraps the sum naturally
    assign w_branch_offset = {{(PC_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign w_branch_target = pc_plus4 + w_branch_offset;

    // Pseudo-direct jump keeps the region bits of the sequential successor
    assign w_jump_target   = {pc_plus4[PC_WIDTH-1:28], instr[25:0], 2'b00};

    // The opcode field does not steer target selection; the decoder does
    assign w_unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = w_jump_target;
        end else if (branch && zero) begin
            next_pc = w_branch_target;
        end
    end

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the PC, fetches one word at a
//            time over a req/ready + rvalid handshake, latches it into the
//            IR for the decoder and steps the PC when the datapath retires.
// Ports    : clk          in   1         system clock, rising edge
//            rst_n        in   1         asynchronous active-low reset
//            imem         master        instruction-memory bundle
//            instr        out  32        IR contents
//            op           out  6         instr[31:26]
//            funct        out  6         instr[5:0]
//            instr_valid  out  1         IR holds the executing instruction
//            exec_done    in   1         datapath retires current instruction
//            branch       in   1         decoder Branch
//            jump         in   1         decoder Jump
//            zero         in   1         ALU zero flag
//            pc           out  PC_WIDTH  current PC
//            pc_plus4     out  PC_WIDTH  pc + 4
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic [5:0]          op,
    output logic [5:0]          funct,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                branch,
    input  logic                jump,
    input  logic                zero,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4
);

    localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                w_ir_load;
    logic                w_pc_load;

    assign w_pc_plus4 = r_pc + c_pc_step;

    next_pc_logic #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc (
        .pc_plus4 (w_pc_plus4),
        .instr    (r_ir),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (w_next_pc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and load strobes. rvalid is only honoured in WAIT or on the
    // accepting REQ cycle, so a response left over from an aborted fetch is
    // never mistaken for the new one while IDLE or stalled in REQ.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end
            REQ: begin
                if (imem.imem_ready) begin
                    if (imem.imem_rvalid) begin
                        w_ir_load   = 1'b1;
                        w_state_nxt = EXEC;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // PC and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_ir_load) begin
                r_ir <= imem.imem_rdata;
            end
        end
    end

    // Request and address come straight from state/PC, so they cannot move
    // while a request waits for imem_ready.
    assign imem.imem_req  = (r_state == REQ);
    assign imem.imem_addr = r_pc;

    assign instr       = r_ir;
    assign op          = instr_op(r_ir);
    assign funct       = instr_funct(r_ir);
    assign instr_valid = (r_state == EXEC);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit. Expected fetch
//            addresses and instruction words are queued when stimulus is
//            driven and popped when the DUT issues / presents them.
//            A second fetch_unit (reset PC at the top of the address space)
//            exercises PC wrap; a standalone next_pc_logic covers targets
//            unreachable from the main instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] c_junk = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exec_done, branch, jump, zero;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  op, funct;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_instr[$];
    logic [31:0] q_npc[$];

    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    fetch_unit_if #(.PC_WIDTH(32)) bus ();

    fetch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    // ---------------- wrap DUT (zero-latency memory) ----------------
    fetch_unit_if #(.PC_WIDTH(32)) bus_w ();
    logic        aux_done;
    logic [31:0] a_instr, a_pc, a_pc_plus4;
    logic [5:0]  a_op, a_funct;
    logic        a_valid;

    assign bus_w.imem_ready  = 1'b1;
    assign bus_w.imem_rvalid = 1'b1;
    assign bus_w.imem_rdata  = 32'h0109_5020;

    fetch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus_w),
        .instr       (a_instr),
        .op          (a_op),
        .funct       (a_funct),
        .instr_valid (a_valid),
        .exec_done   (aux_done),
        .branch      (1'b0),
        .jump        (1'b0),
        .zero        (1'b0),
        .pc          (a_pc),
        .pc_plus4    (a_pc_plus4)
    );

    // ---------------- standalone next-PC unit ----------------
    logic [31:0] npc_pc_plus4, npc_instr, npc_next;
    logic        npc_branch, npc_jump, npc_zero;

    next_pc_logic #(.PC_WIDTH(32)) u_npc (
        .pc_plus4 (npc_pc_plus4),
        .instr    (npc_instr),
        .branch   (npc_branch),
        .jump     (npc_jump),
        .zero     (npc_zero),
        .next_pc  (npc_next)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk32("rst_pc", pc, 32'h0);
        chk32("rst_ir", instr, 32'h0);
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk32("rst_wrap_pc", a_pc, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        chk1("idle_req", bus.imem_req, 1'b0);
        tick();
    endtask

    // One complete fetch + execute. rdy_dly: cycles before imem_ready;
    // rv_dly: 0 = data on the accept cycle, n = rvalid on the n-th WAIT cycle.
    task automatic do_instr(input logic [31:0] exp_addr, input logic [31:0] word,
                            input int rdy_dly, input int rv_dly,
                            input logic j, input logic b, input logic z,
                            input logic [31:0] exp_next);
        logic [31:0] ir_before;
        logic [31:0] exp_w;
        int          guard;
        q_addr.push_back(exp_addr);
        q_instr.push_back(word);
        guard = 0;
        while (bus.imem_req !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        chk1("req_seen", bus.imem_req, 1'b1);
        ir_before = instr;
        for (int i = 0; i < rdy_dly; i++) begin
            chk1("stall_req", bus.imem_req, 1'b1);
            chk32("stall_addr", bus.imem_addr, q_addr[0]);
            chk32("stall_ir", instr, ir_before);
            tick();
        end
        bus.imem_ready = 1'b1;
        if (rv_dly == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word;
        end
        chk1("accept_req", bus.imem_req, 1'b1);
        chk32("fetch_addr", bus.imem_addr, q_addr.pop_front());
        tick();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = c_junk;
        if (rv_dly > 0) begin
            for (int i = 0; i < rv_dly; i++) begin
                chk1("wait_req", bus.imem_req, 1'b0);
                chk1("wait_valid", instr_valid, 1'b0);
                chk32("wait_ir", instr, ir_before);
                if (i == rv_dly - 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = word;
                end
                tick();
            end
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = c_junk;
        end
        exp_w = q_instr.pop_front();
        chk1("exec_valid", instr_valid, 1'b1);
        chk32("exec_ir", instr, exp_w);
        chk32("exec_op", 32'(op), 32'(exp_w[31:26]));
        chk32("exec_funct", 32'(funct), 32'(exp_w[5:0]));
        chk32("exec_pc", pc, exp_addr);
        chk32("exec_pc_plus4", pc_plus4, exp_addr + 32'd4);
        // A cycle without retirement: decoder flags and bus noise must be ignored
        exec_done       = 1'b0;
        branch          = 1'b1;
        jump            = 1'b1;
        zero            = 1'b1;
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b1;
        tick();
        chk1("hold_valid", instr_valid, 1'b1);
        chk32("hold_pc", pc, exp_addr);
        chk32("hold_ir", instr, exp_w);
        exec_done = 1'b1;
        jump      = j;
        branch    = b;
        zero      = z;
        tick();
        exec_done       = 1'b0;
        jump            = 1'b0;
        branch          = 1'b0;
        zero            = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        chk1("retire_valid", instr_valid, 1'b0);
        chk32("next_pc", pc, exp_next);
        chk32("retire_ir", instr, exp_w);
        chk1("next_req", bus.imem_req, 1'b1);
        chk32("next_addr", bus.imem_addr, exp_next);
    endtask

    task automatic npc_case(input string tag, input logic [31:0] p4, input logic [31:0] w,
                            input logic j, input logic b, input logic z,
                            input logic [31:0] exp_next);
        q_npc.push_back(exp_next);
        npc_pc_plus4 = p4;
        npc_instr    = w;
        npc_jump     = j;
        npc_branch   = b;
        npc_zero     = z;
        #1;
        chk32(tag, npc_next, q_npc.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n           = 1'b0;
        exec_done       = 1'b0;
        branch          = 1'b0;
        jump            = 1'b0;
        zero            = 1'b0;
        aux_done        = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = c_junk;
        npc_pc_plus4    = '0;
        npc_instr       = '0;
        npc_branch      = 1'b0;
        npc_jump        = 1'b0;
        npc_zero        = 1'b0;
        #2;

        // Zero-latency memory, sequential retirement: 0, 4, 8, C
        do_reset();
        do_instr(32'h0000_0000, 32'h0109_5020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        do_instr(32'h0000_0004, 32'h0232_9822, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
        do_instr(32'h0000_0008, 32'h2108_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
        do_instr(32'h0000_000C, 32'hAC09_0008, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);

        // PC wrap on the high-reset instance, parked in EXEC at 0xFFFF_FFFC
        chk1("wrap_valid", a_valid, 1'b1);
        chk32("wrap_pc", a_pc, 32'hFFFF_FFFC);
        chk32("wrap_pc_plus4", a_pc_plus4, 32'h0000_0000);
        aux_done = 1'b1;
        tick();
        aux_done = 1'b0;
        chk32("wrap_next_pc", a_pc, 32'h0000_0000);
        chk32("wrap_next_addr", bus_w.imem_addr, 32'h0000_0000);
        chk1("wrap_next_req", bus_w.imem_req, 1'b1);

        // Stalled memory: ready after 2 cycles, rvalid 3 cycles later (lw)
        do_reset();
        do_instr(32'h0000_0000, 32'h8C08_0004, 2, 3, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

        // Jump with branch/zero also set (jump wins) to 0x40, then beq cases
        do_instr(32'h0000_0004, 32'h0800_0010, 1, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        do_instr(32'h0000_0040, 32'h1000_FFFE, 0, 1, 1'b0, 1'b1, 1'b1, 32'h0000_003C);
        do_instr(32'h0000_003C, 32'h0800_0010, 0, 2, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        do_instr(32'h0000_0040, 32'h1000_FFFE, 1, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0044);
        do_instr(32'h0000_0044, 32'h1000_0005, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0048);

        // Reset while in WAIT; a stale rvalid after release must be dropped
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        chk32("abort_addr", bus.imem_addr, 32'h0000_0048);
        tick();
        bus.imem_ready = 1'b0;
        chk1("abort_wait_req", bus.imem_req, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk32("abort_pc", pc, 32'h0);
        chk32("abort_ir", instr, 32'h0);
        chk1("abort_req", bus.imem_req, 1'b0);
        chk1("abort_valid", instr_valid, 1'b0);
        tick();
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0001;
        tick();
        chk1("stale_req", bus.imem_req, 1'b1);
        chk32("stale_addr", bus.imem_addr, 32'h0);
        chk32("stale_ir_idle", instr, 32'h0);
        tick();
        chk32("stale_ir_req", instr, 32'h0);
        chk1("stale_valid", instr_valid, 1'b0);
        chk32("stale_addr_hold", bus.imem_addr, 32'h0);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = c_junk;
        do_instr(32'h0000_0000, 32'h0109_5020, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

        // Standalone next-PC unit
        npc_case("npc_jump_prio", 32'h1000_0014, 32'h0800_0100, 1'b1, 1'b1, 1'b1, 32'h1000_0400);
        npc_case("npc_br_neg_wrap", 32'h0000_0004, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        npc_case("npc_br_pos_wrap", 32'hFFFF_FFF0, 32'h1000_0007, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
        npc_case("npc_br_not_taken", 32'h0000_0044, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0044);
        npc_case("npc_seq", 32'h0000_0044, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 32'h0000_0044);

        chk32("sb_addr_empty", 32'(q_addr.size()), 32'd0);
        chk32("sb_instr_empty", 32'(q_instr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
